// File: rtl/shift_ctrl.sv
// shift_ctrl: serializes a WIDTH-bit word LSB first onto out, strobing sel once per DIV-cycle bit period.
// Define SHIFT_CTRL_PARITY_EN to append an even-parity bit after the MSB (WIDTH+1 strobes per transfer).
module shift_ctrl #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             out,
    output logic             sel,
    output logic             busy,
    output logic             done
);

`ifdef SHIFT_CTRL_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    // The divider keeps at least one bit so DIV=1 still elaborates; it then never leaves 0.
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(NBITS);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [NBITS-1:0] frame;
    logic [NBITS-1:0] sreg;
    logic [DW-1:0]    div_cnt;
    logic [CW-1:0]    bit_cnt;
    logic             start;
    logic             strobe;

`ifdef SHIFT_CTRL_PARITY_EN
    assign frame = {^din, din};
`else
    assign frame = din;
`endif

    assign strobe = (state == SHIFT) && (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no branch can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        out       = 1'b0;
        sel       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    start     = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                out  = sreg[0];
                sel  = strobe;
                if (strobe && (bit_cnt == BIT_LAST)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg    <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (start) begin
            sreg    <= frame;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (state == SHIFT) begin
            if (strobe) begin
                div_cnt <= '0;
                sreg    <= sreg >> 1;
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_shift_ctrl.sv
// tb_shift_ctrl: directed and random stimulus on a DIV=4 and a DIV=1 instance sharing inputs,
// checked every cycle against an offset-based transfer model plus literal expectations.
module tb_shift_ctrl;

    localparam int WIDTH = 8;
`ifdef SHIFT_CTRL_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif
    localparam int L0   = NB * 4;
    localparam int L1   = NB * 1;
    localparam int LOGN = 8192;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             out0, sel0, busy0, done0;
    logic             out1, sel1, busy1, done1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [3:0] log_q [2][LOGN];

    always #5 clk = ~clk;

    shift_ctrl #(.WIDTH(WIDTH), .DIV(4)) u_dut0 (
        .clk(clk), .rst(rst), .din(din), .load(load),
        .out(out0), .sel(sel0), .busy(busy0), .done(done0)
    );

    shift_ctrl #(.WIDTH(WIDTH), .DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .din(din), .load(load),
        .out(out1), .sel(sel1), .busy(busy1), .done(done1)
    );

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] frame_of(input logic [WIDTH-1:0] w);
`ifdef SHIFT_CTRL_PARITY_EN
        return {^w, w};
`else
        return w;
`endif
    endfunction

    // Expected {busy,done,sel,out} r cycles after the load cycle of a transfer with period dv.
    function automatic logic [3:0] model_at(input int r, input int dv, input logic [NB-1:0] fr);
        if (r >= 1 && r <= NB * dv) return {1'b1, 1'b0, 1'((r % dv) == 0), fr[(r - 1) / dv]};
        if (r == NB * dv + 1) return 4'b1100;
        return 4'b0000;
    endfunction

    initial begin : monitor
        bit            on [2];
        int            st [2];
        int            dv [2];
        logic [NB-1:0] fr [2];
        logic [3:0]    got;
        logic [3:0]    exp;
        on = '{0, 0};
        st = '{0, 0};
        dv = '{4, 1};
        fr = '{'0, '0};
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                got = (i == 0) ? {busy0, done0, sel0, out0} : {busy1, done1, sel1, out1};
                exp = on[i] ? model_at(cyc - st[i], dv[i], fr[i]) : 4'b0000;
                check($sformatf("dut%0d cycle %0d {busy,done,sel,out}", i, cyc), got, exp);
                if (cyc < LOGN) log_q[i][cyc] = got;
                if (rst) begin
                    on[i] = 0;
                end else if (load && (!on[i] || (cyc - st[i]) > NB * dv[i] + 1)) begin
                    on[i] = 1;
                    st[i] = cyc;
                    fr[i] = frame_of(din);
                end
            end
            cyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : driver
        logic [8:0] a5_bits;
        logic [8:0] one_bits;
        int         c0, c1, c2, c3, n_sel, n_done;
        logic       any_one;
`ifdef SHIFT_CTRL_PARITY_EN
        a5_bits  = 9'b0_1010_0101;
        one_bits = 9'b1_0000_0001;
`else
        a5_bits  = 9'b0_1010_0101;
        one_bits = 9'b0_0000_0001;
`endif
        rst  = 1'b1;
        load = 1'b0;
        din  = '0;

        // Model pins against hand-derived values.
        check("pin a5 first sel", model_at(4, 4, frame_of(8'hA5)), 4'b1011);
        check("pin a5 second sel", model_at(8, 4, frame_of(8'hA5)), 4'b1010);
        check("pin a5 mid period", model_at(2, 4, frame_of(8'hA5)), 4'b1001);
        check("pin a5 done", model_at(L0 + 1, 4, frame_of(8'hA5)), 4'b1100);
        check("pin a5 idle after", model_at(L0 + 2, 4, frame_of(8'hA5)), 4'b0000);
        check("pin div1 first", model_at(1, 1, frame_of(8'h01)), 4'b1011);
        check("pin div1 second", model_at(2, 1, frame_of(8'h01)), 4'b1010);

        tick(3);
        rst = 1'b0;
        check("reset state dut0", {busy0, done0, sel0, out0}, 4'b0000);
        check("reset state dut1", {busy1, done1, sel1, out1}, 4'b0000);

        // Basic serialization of 8'hA5; the DIV=1 instance serializes it too.
        c0   = cyc;
        din  = 8'hA5;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(45);
        check("a5 load cycle idle", log_q[0][c0], 4'b0000);
        check("a5 busy after load", 4'(log_q[0][c0 + 1][3]), 4'd1);
        check("a5 no sel before 4", 4'(log_q[0][c0 + 3][1]), 4'd0);
        for (int k = 0; k < NB; k++) begin
            check($sformatf("a5 sel/out bit %0d", k), 4'(log_q[0][c0 + 4 * (k + 1)][1:0]),
                  {2'b00, 1'b1, a5_bits[k]});
        end
        check("a5 done cycle", log_q[0][c0 + L0 + 1], 4'b1100);
        check("a5 idle after done", log_q[0][c0 + L0 + 2], 4'b0000);

        // Minimum divider with 8'h01.
        c1   = cyc;
        din  = 8'h01;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(45);
        for (int r = 1; r <= NB; r++) begin
            check($sformatf("div1 cycle %0d", r), log_q[1][c1 + r], {3'b101, one_bits[r - 1]});
        end
        check("div1 done", log_q[1][c1 + L1 + 1], 4'b1100);

        // Load held with 8'hFF while 8'h00 shifts, then back-to-back capture of 8'hFF.
        c2   = cyc;
        din  = 8'h00;
        load = 1'b1;
        tick(1);
        din = 8'hFF;
        tick(L0 + 2);
        load = 1'b0;
        tick(L0 + 6);
        n_sel   = 0;
        any_one = 1'b0;
        for (int r = 1; r <= L0; r++) begin
            if (log_q[0][c2 + r][1]) begin
                n_sel++;
                any_one = any_one | log_q[0][c2 + r][0];
            end
        end
        check("held load sel count", 4'(n_sel), 4'(NB));
        check("held load sampled bits", 4'(any_one), 4'd0);
        check("held load done", log_q[0][c2 + L0 + 1], 4'b1100);
        check("back-to-back idle gap", log_q[0][c2 + L0 + 2], 4'b0000);
        check("back-to-back new capture", log_q[0][c2 + L0 + 3], 4'b1001);

        // Mid-transfer reset with a simultaneous load, then a load on the first cycle after reset.
        c3   = cyc;
        din  = 8'hA5;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        tick(9);
        rst  = 1'b1;
        load = 1'b1;
        tick(1);
        rst = 1'b0;
        din = 8'h3C;
        tick(1);
        load = 1'b0;
        tick(45);
        n_done = 0;
        for (int r = 1; r <= 11; r++) n_done += int'(log_q[0][c3 + r][2]);
        check("reset abort no done", 4'(n_done), 4'd0);
        check("reset clears dut0", log_q[0][c3 + 11], 4'b0000);
        check("reset beats load dut1", log_q[1][c3 + 11], 4'b0000);
        check("load right after reset", log_q[0][c3 + 12], 4'b1000);

        // Random traffic; the monitor checks every cycle.
        for (int i = 0; i < 2000; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            load = ($urandom_range(0, 3) == 0);
            din  = WIDTH'($urandom);
            tick(1);
        end
        rst  = 1'b0;
        load = 1'b0;
        tick(L0 + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of data bits per word (WIDTH >= 2).
REQ-002 The block SHALL have parameter DIV, default 4, giving the number of clk cycles per serial bit (DIV >= 1).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all logic updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-006 The block SHALL have port din, input, WIDTH bits, the parallel word to serialize.
REQ-007 The block SHALL have port load, input, 1 bit, a request to capture din and start a transfer.
REQ-008 The block SHALL have port out, output, 1 bit, the serial data feeding the downstream shift cell's in.
REQ-009 The block SHALL have port sel, output, 1 bit, a one-cycle capture strobe feeding the downstream shift cell's sel.
REQ-010 The block SHALL have port busy, output, 1 bit, high while a transfer is in progress.
REQ-011 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking transfer completion.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE, load=1 at a rising edge SHALL capture din into an internal shift register, clear the divider and bit counters, and move the FSM to SHIFT.
REQ-014 In SHIFT, a divider SHALL count 0..DIV-1 and wrap to 0; sel SHALL be 1 only in cycles where the divider equals DIV-1.
REQ-015 out SHALL present the current bit, LSB first, throughout each bit period, including the sel cycle.
REQ-016 At the edge that ends a sel cycle, the shift register SHALL shift right by one and the bit counter SHALL increment.
REQ-017 The first sel SHALL occur in the DIV-th cycle after the load cycle; each later sel SHALL follow the previous one by exactly DIV cycles.
REQ-018 After the last bit's sel, the FSM SHALL enter DONE for exactly one cycle with done=1, then return to IDLE.
REQ-019 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-020 load SHALL be ignored in SHIFT and DONE; din captured at the start SHALL stay unchanged for the whole transfer.
REQ-021 A load in the first IDLE cycle after DONE SHALL be accepted, giving back-to-back transfers with one idle cycle between done and the next busy.
REQ-022 With DIV=1, sel SHALL be 1 in every SHIFT cycle.
REQ-023 out SHALL be 0 in IDLE and DONE.

Reset
REQ-024 rst=1 at a rising edge SHALL force the FSM to IDLE and clear the shift register, bit counter and divider.
REQ-025 rst=1 at a rising edge SHALL force out=0, sel=0, busy=0 and done=0.
REQ-026 rst SHALL take priority over load.
REQ-027 rst asserted mid-transfer SHALL abort the transfer with no further sel or done pulses.
REQ-028 After rst deasserts, the block SHALL accept a load on the first cycle.

Configuration
REQ-029 With macro SHIFT_CTRL_PARITY_EN defined, one extra bit SHALL be sent after the MSB, equal to the even-parity XOR of the captured word, with its own sel strobe, giving WIDTH+1 strobes per transfer.
REQ-030 With SHIFT_CTRL_PARITY_EN undefined, exactly WIDTH strobes SHALL be issued and no parity logic SHALL exist.

Verification
REQ-031 Basic serialization: WIDTH=8, DIV=4, load with din=8'hA5 at cycle 0 -> sel in cycles 4,8,...,32; out at those cycles 1,0,1,0,0,1,0,1; done=1 in cycle 33; busy=1 in cycles 1..33.
REQ-032 Minimum divider: DIV=1, din=8'h01 -> sel=1 in cycles 1..8; out=1 only in cycle 1; done in cycle 9.
REQ-033 Load while busy: load=1 with din=8'hFF held throughout a transfer of 8'h00 -> all sampled bits 0; exactly 8 sel pulses; next transfer starts only from IDLE.
REQ-034 Mid-transfer reset: rst=1 in cycle 10 of the REQ-031 transfer -> from cycle 11, out=sel=busy=done=0; no done pulse.
REQ-035 Parity enabled: SHIFT_CTRL_PARITY_EN defined, din=8'h07 -> 9 sel pulses; 9th sampled bit=1; done in cycle 37 (DIV=4).
REQ-036 Back-to-back: load held at 1 continuously -> done, one IDLE cycle, then busy=1 again with a new capture.
